// File: rtl/mnist_batch_sequencer_if.sv
// Handshake bundle between the batch sequencer and the board / inference wrapper.
// master is the sequencer side, slave is the board/wrapper side.
interface mnist_batch_sequencer_if #(
  parameter int unsigned IMAGES  = 10,
  parameter int unsigned CLASSES = 10
);
  logic                  run;
  logic [4*IMAGES-1:0]   labels;
  logic                  ready;
  logic [CLASSES-1:0]    classes;
  logic [3:0]            image_num;
  logic                  start_comp_n;
  logic                  busy;
  logic                  done;
  logic                  error;
  logic [4:0]            correct_cnt;
  logic [3:0]            last_class;

  modport master (
    input  run, labels, ready, classes,
    output image_num, start_comp_n, busy, done, error, correct_cnt, last_class
  );

  modport slave (
    output run, labels, ready, classes,
    input  image_num, start_comp_n, busy, done, error, correct_cnt, last_class
  );
endinterface

// File: rtl/mnist_batch_sequencer.sv
// Walks the MNIST wrapper through a batch of stored images, pulsing start per image,
// capturing each one-hot result and scoring it against a per-image label.
module mnist_batch_sequencer #(
  parameter int unsigned IMAGES    = 10,
  parameter int unsigned CLASSES   = 10,
  parameter int unsigned START_LEN = 4,
  parameter int unsigned TIMEOUT   = 2**20
) (
  input  logic                    clk,
  input  logic                    reset_n,
  mnist_batch_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StWaitAck,
    StWaitRdy,
    StCheck,
    StNext,
    StDone
  } state_e;

  localparam logic [20:0] StartLast   = 21'(START_LEN - 1);
  localparam logic [20:0] TimeoutLast = 21'(TIMEOUT - 1);
  localparam logic [3:0]  LastImage   = 4'(IMAGES - 1);

  state_e               state_q;
  logic                 run_q;
  logic [20:0]          timer_q;
  logic [CLASSES-1:0]   classes_q;
  logic [3:0]           image_num_q;
  logic [3:0]           last_class_q;
  logic [4:0]           correct_cnt_q;
  logic                 start_n_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 error_q;

  logic                 run_rise;
  logic [7:0]           hot_cnt;
  logic [3:0]           hot_idx;
  logic [3:0]           label_arr [16];
  logic [3:0]           label_cur;

  assign run_rise = bus.run & ~run_q;

  // Unused label slots read as 15 so they can never match a decoded class.
  for (genvar g = 0; g < 16; g++) begin : g_label
    if (g < IMAGES) begin : g_used
      assign label_arr[g] = bus.labels[4*g +: 4];
    end else begin : g_unused
      assign label_arr[g] = 4'hf;
    end
  end

  assign label_cur = label_arr[image_num_q];

  always_comb begin
    hot_cnt = '0;
    hot_idx = 4'hf;
    for (int unsigned i = 0; i < CLASSES; i++) begin
      if (classes_q[i]) begin
        hot_cnt = hot_cnt + 8'd1;
        hot_idx = 4'(i);
      end
    end
  end

  // Timer restarts on every state change; each transition below clears it explicitly.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      run_q         <= 1'b0;
      timer_q       <= '0;
      classes_q     <= '0;
      image_num_q   <= '0;
      last_class_q  <= 4'hf;
      correct_cnt_q <= '0;
      start_n_q     <= 1'b1;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      run_q   <= bus.run;
      timer_q <= timer_q + 21'd1;
      unique case (state_q)
        StIdle, StDone: begin
          if (run_rise) begin
            state_q       <= StStart;
            timer_q       <= '0;
            correct_cnt_q <= '0;
            error_q       <= 1'b0;
            done_q        <= 1'b0;
            busy_q        <= 1'b1;
            image_num_q   <= '0;
            start_n_q     <= 1'b0;
          end
        end
        StStart: begin
          if (timer_q == StartLast) begin
            start_n_q <= 1'b1;
            state_q   <= StWaitAck;
            timer_q   <= '0;
          end
        end
        StWaitAck: begin
          // A ready still high from the previous image must drop before a result is taken.
          if (!bus.ready) begin
            state_q <= StWaitRdy;
            timer_q <= '0;
          end else if (timer_q == TimeoutLast) begin
            error_q <= 1'b1;
            state_q <= StNext;
            timer_q <= '0;
          end
        end
        StWaitRdy: begin
          if (bus.ready) begin
            classes_q <= bus.classes;
            state_q   <= StCheck;
            timer_q   <= '0;
          end else if (timer_q == TimeoutLast) begin
            error_q <= 1'b1;
            state_q <= StNext;
            timer_q <= '0;
          end
        end
        StCheck: begin
          if (hot_cnt == 8'd1) begin
            last_class_q <= hot_idx;
            if (hot_idx == label_cur && correct_cnt_q != 5'd31) begin
              correct_cnt_q <= correct_cnt_q + 5'd1;
            end
          end else begin
            last_class_q <= 4'hf;
            error_q      <= 1'b1;
          end
          state_q <= StNext;
          timer_q <= '0;
        end
        StNext: begin
          timer_q <= '0;
          if (image_num_q == LastImage) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= StDone;
          end else begin
            image_num_q <= image_num_q + 4'd1;
            start_n_q   <= 1'b0;
            state_q     <= StStart;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.image_num    = image_num_q;
  assign bus.start_comp_n = start_n_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.error        = error_q;
  assign bus.correct_cnt  = correct_cnt_q;
  assign bus.last_class   = last_class_q;

endmodule

// File: tb/tb_mnist_batch_sequencer.sv
// Bench for mnist_batch_sequencer: a behavioural wrapper model answers each start pulse,
// and batch results are checked against a table of constants and a per-batch reference model.
module tb_mnist_batch_sequencer;
  localparam int unsigned IMAGES    = 10;
  localparam int unsigned CLASSES   = 10;
  localparam int unsigned START_LEN = 4;
  localparam int unsigned TIMEOUT   = 64;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;

  mnist_batch_sequencer_if #(.IMAGES(IMAGES), .CLASSES(CLASSES)) bus ();

  mnist_batch_sequencer #(
    .IMAGES   (IMAGES),
    .CLASSES  (CLASSES),
    .START_LEN(START_LEN),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  logic [CLASSES-1:0]  cfg_cls [IMAGES];
  int                  cfg_lat [IMAGES];
  bit                  cfg_hang [IMAGES];
  logic [4*IMAGES-1:0] cfg_labels = '0;

  int   wm_phase  = 0;
  int   wm_cnt    = 0;
  int   wm_img    = 0;
  int   pulse_cnt = 0;
  int   bad_len   = 0;
  int   low_len   = 0;
  int   high_len  = 0;
  int   gap_before [IMAGES];
  logic sc_prev   = 1'b1;

  int m_last = 15;
  int m_corr = 0;
  int m_err  = 0;

  typedef struct {
    logic [CLASSES-1:0] cls;
    logic [3:0]         label;
    int                 exp_last;
    int                 exp_corr;
    int                 exp_err;
  } vec_t;

  vec_t tbl [9];

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Wrapper model: drops ready one cycle after a start pulse begins, raises it with the
  // configured result cfg_lat cycles later; a hung image never drops ready.
  initial begin
    bus.ready   = 1'b1;
    bus.classes = '0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        wm_phase  = 0;
        bus.ready = 1'b1;
      end else begin
        if (wm_phase == 2) begin
          wm_cnt++;
          if (wm_cnt >= cfg_lat[wm_img]) begin
            bus.ready   = 1'b1;
            bus.classes = cfg_cls[wm_img];
            wm_phase    = 0;
          end
        end else if (wm_phase == 1) begin
          if (!cfg_hang[wm_img]) begin
            bus.ready   = 1'b0;
            bus.classes = CLASSES'($urandom);
            wm_cnt      = 0;
            wm_phase    = 2;
          end else begin
            wm_phase = 0;
          end
        end
        if (!bus.start_comp_n && sc_prev) begin
          pulse_cnt++;
          wm_img             = int'(bus.image_num);
          gap_before[wm_img] = high_len;
          low_len            = 1;
          wm_phase           = 1;
        end else if (!bus.start_comp_n) begin
          low_len++;
        end else if (!sc_prev) begin
          if (low_len != START_LEN) bad_len++;
          high_len = 1;
        end else begin
          high_len++;
        end
      end
      sc_prev = bus.start_comp_n;
    end
  end

  task automatic model_batch();
    int idx;
    m_corr = 0;
    m_err  = 0;
    for (int i = 0; i < IMAGES; i++) begin
      if (cfg_hang[i]) begin
        m_err = 1;
      end else if ($countones(cfg_cls[i]) == 1) begin
        idx = 0;
        for (int j = 0; j < CLASSES; j++) if (cfg_cls[i][j]) idx = j;
        m_last = idx;
        if (idx == int'(cfg_labels[4*i +: 4])) m_corr++;
      end else begin
        m_last = 15;
        m_err  = 1;
      end
    end
  endtask

  task automatic set_all(input logic [CLASSES-1:0] cls, input logic [3:0] lbl, input int lat);
    for (int i = 0; i < IMAGES; i++) begin
      cfg_cls[i]             = cls;
      cfg_labels[4*i +: 4]   = lbl;
      cfg_lat[i]             = lat;
      cfg_hang[i]            = 1'b0;
    end
  endtask

  task automatic set_identity(input int lat);
    for (int i = 0; i < IMAGES; i++) begin
      cfg_cls[i]           = '0;
      cfg_cls[i][i]        = 1'b1;
      cfg_labels[4*i +: 4] = 4'(i);
      cfg_lat[i]           = lat;
      cfg_hang[i]          = 1'b0;
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_image_num"}, int'(bus.image_num), 0);
    check({tag, "_start_n"}, int'(bus.start_comp_n), 1);
    check({tag, "_busy"}, int'(bus.busy), 0);
    check({tag, "_done"}, int'(bus.done), 0);
    check({tag, "_error"}, int'(bus.error), 0);
    check({tag, "_correct"}, int'(bus.correct_cnt), 0);
    check({tag, "_last"}, int'(bus.last_class), 15);
  endtask

  task automatic start_batch();
    bus.labels = cfg_labels;
    @(negedge clk);
    bus.run = 1'b0;
    @(negedge clk);
    bus.run   = 1'b1;
    pulse_cnt = 0;
    bad_len   = 0;
    @(negedge clk);
    check("start_latency", int'(bus.start_comp_n), 0);
    check("busy_set", int'(bus.busy), 1);
    check("done_clr", int'(bus.done), 0);
    check("correct_clr", int'(bus.correct_cnt), 0);
    check("error_clr", int'(bus.error), 0);
    check("image_zero", int'(bus.image_num), 0);
  endtask

  task automatic wait_done(input bit toggle);
    int n;
    n = 0;
    while (!bus.done && n < 8000) begin
      @(negedge clk);
      n++;
      if (toggle && n < 60 && (n % 7) == 0) bus.run = ~bus.run;
      if (toggle && n == 60) bus.run = 1'b1;
    end
    check("batch_finished", int'(bus.done), 1);
  endtask

  task automatic check_results(input string tag);
    model_batch();
    check({tag, "_correct"}, int'(bus.correct_cnt), m_corr);
    check({tag, "_error"}, int'(bus.error), m_err);
    check({tag, "_last"}, int'(bus.last_class), m_last);
    check({tag, "_image_num"}, int'(bus.image_num), IMAGES - 1);
    check({tag, "_busy"}, int'(bus.busy), 0);
    check({tag, "_start_idle"}, int'(bus.start_comp_n), 1);
    check({tag, "_pulses"}, pulse_cnt, IMAGES);
    check({tag, "_pulse_len"}, bad_len, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int r;
    int lbl;

    tbl[0] = '{10'b0000000001, 4'd0,  0,  10, 0};
    tbl[1] = '{10'b1000000000, 4'd9,  9,  10, 0};
    tbl[2] = '{10'b0000100000, 4'd5,  5,  10, 0};
    tbl[3] = '{10'b0000100000, 4'd4,  5,  0,  0};
    tbl[4] = '{10'b0000000011, 4'd0,  15, 0,  1};
    tbl[5] = '{10'b0000000000, 4'd0,  15, 0,  1};
    tbl[6] = '{10'b1111111111, 4'd9,  15, 0,  1};
    tbl[7] = '{10'b0010000000, 4'd12, 7,  0,  0};
    tbl[8] = '{10'b0010000000, 4'd7,  7,  10, 0};

    set_identity(10);
    bus.run    = 1'b0;
    bus.labels = '0;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_vals("post_reset_idle");

    for (int t = 0; t < 9; t++) begin
      set_all(tbl[t].cls, tbl[t].label, 10);
      start_batch();
      wait_done(1'b0);
      check("tbl_correct", int'(bus.correct_cnt), tbl[t].exp_corr);
      check("tbl_error", int'(bus.error), tbl[t].exp_err);
      check("tbl_last", int'(bus.last_class), tbl[t].exp_last);
      check("tbl_pulses", pulse_cnt, IMAGES);
      m_last = tbl[t].exp_last;
    end

    // All ten images answered correctly after a 50-cycle wrapper latency.
    set_identity(50);
    start_batch();
    wait_done(1'b0);
    check_results("all_ok");
    check("all_ok_const", int'(bus.correct_cnt), 10);

    // Image 3 answers class 7 against label 2.
    set_identity(50);
    cfg_cls[3]    = '0;
    cfg_cls[3][7] = 1'b1;
    cfg_labels[4*3 +: 4] = 4'd2;
    start_batch();
    wait_done(1'b0);
    check_results("one_wrong");
    check("one_wrong_const", int'(bus.correct_cnt), 9);
    check("one_wrong_last", int'(bus.last_class), 9);

    // Image 5 never drops ready: WAIT_ACK times out, batch carries on.
    set_identity(20);
    cfg_hang[5] = 1'b1;
    start_batch();
    wait_done(1'b0);
    check_results("hang");
    check("hang_error", int'(bus.error), 1);
    check("hang_gap", gap_before[6], TIMEOUT + 1);

    // Two-hot result on image 0.
    set_identity(12);
    cfg_cls[0] = 10'b0000000011;
    start_batch();
    n = 0;
    while (bus.image_num != 4'd1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("twohot_reach_img1", int'(bus.image_num), 1);
    check("twohot_last", int'(bus.last_class), 15);
    check("twohot_error", int'(bus.error), 1);
    check("twohot_correct", int'(bus.correct_cnt), 0);
    wait_done(1'b0);
    check_results("twohot");

    // Asynchronous reset in WAIT_RDY of image 4, then a clean restart.
    set_identity(30);
    start_batch();
    n = 0;
    while (!(bus.image_num == 4'd4 && wm_phase == 2 && wm_cnt > 5) && n < 4000) begin
      @(negedge clk);
      n++;
    end
    check("rst_reach_img4", int'(bus.image_num), 4);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_vals("mid_reset");
    bus.run = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    m_last  = 15;
    @(negedge clk);
    check_reset_vals("after_mid_reset");
    start_batch();
    wait_done(1'b0);
    check_results("restart");

    // Run toggled while busy and left high past DONE must not retrigger.
    set_identity(15);
    start_batch();
    wait_done(1'b1);
    check_results("toggle");
    repeat (50) @(negedge clk);
    check("hold_done", int'(bus.done), 1);
    check("hold_busy", int'(bus.busy), 0);
    check("hold_no_pulse", pulse_cnt, IMAGES);
    start_batch();
    wait_done(1'b0);
    check_results("fresh_rise");

    for (int b = 0; b < 6; b++) begin
      for (int i = 0; i < IMAGES; i++) begin
        lbl = ($urandom_range(0, 9) == 0) ? int'($urandom_range(10, 15)) : int'($urandom_range(0, 9));
        cfg_labels[4*i +: 4] = 4'(lbl);
        cfg_hang[i] = 1'b0;
        cfg_lat[i]  = int'($urandom_range(6, 40));
        cfg_cls[i]  = '0;
        r = int'($urandom_range(0, 99));
        if (r < 10) begin
          cfg_hang[i] = 1'b1;
        end else if (r < 20) begin
          cfg_cls[i] = CLASSES'($urandom);
        end else if (r < 40) begin
          cfg_cls[i][$urandom_range(0, CLASSES - 1)] = 1'b1;
        end else begin
          cfg_cls[i][(lbl < 10) ? lbl : 0] = 1'b1;
        end
      end
      start_batch();
      wait_done(b[0]);
      check_results("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
